// File: rtl/pipeline_control_hazard_pkg.sv
// Shared encodings and stage bundles for the 5-stage pipeline control path.
// Holds the result-select, forward-select, PC-source and ALU-function codes,
// plus the packed control bundles carried by each pipeline register.
package pipeline_control_hazard_pkg;

   localparam int unsigned REG_ADDR_W = 5;
   localparam int unsigned ALU_FN_W   = 3;

   // Writeback result select
   localparam logic [1:0] RESULT_ALU = 2'b00;
   localparam logic [1:0] RESULT_MEM = 2'b01;
   localparam logic [1:0] RESULT_PC4 = 2'b10;
   localparam logic [1:0] RESULT_IMM = 2'b11;

   // EX operand forward select
   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_WB  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;

   // Next-PC select
   localparam logic [1:0] PC_SRC_SEQ    = 2'b00;
   localparam logic [1:0] PC_SRC_TARGET = 2'b01;
   localparam logic [1:0] PC_SRC_JALR   = 2'b10;

   // ALU function codes, shared with the ALU decoder
   localparam logic [ALU_FN_W-1:0] ALU_ADD = 3'b000;
   localparam logic [ALU_FN_W-1:0] ALU_SUB = 3'b001;
   localparam logic [ALU_FN_W-1:0] ALU_AND = 3'b010;
   localparam logic [ALU_FN_W-1:0] ALU_OR  = 3'b011;
   localparam logic [ALU_FN_W-1:0] ALU_SLT = 3'b101;

   // ID/EX bundle: full control plus register addresses
   typedef struct packed {
      logic                  reg_write;
      logic [1:0]            result_src;
      logic                  mem_write;
      logic                  alu_src;
      logic [ALU_FN_W-1:0]   alu_function;
      logic                  beq;
      logic                  bne;
      logic                  jump;
      logic                  jalr;
      logic [REG_ADDR_W-1:0] rs1;
      logic [REG_ADDR_W-1:0] rs2;
      logic [REG_ADDR_W-1:0] rd;
   } ex_ctrl_t;

   // EX/MEM bundle
   typedef struct packed {
      logic                  reg_write;
      logic [1:0]            result_src;
      logic                  mem_write;
      logic [REG_ADDR_W-1:0] rd;
   } mem_ctrl_t;

   // MEM/WB bundle
   typedef struct packed {
      logic                  reg_write;
      logic [1:0]            result_src;
      logic [REG_ADDR_W-1:0] rd;
   } wb_ctrl_t;

   // Forward select for one EX source; MEM beats WB, x0 never forwards
   function automatic logic [1:0] fwd_sel(
      input logic [REG_ADDR_W-1:0] rs,
      input logic                  reg_write_m,
      input logic [REG_ADDR_W-1:0] rd_m,
      input logic                  reg_write_w,
      input logic [REG_ADDR_W-1:0] rd_w
   );
      logic [1:0] sel;
      sel = FWD_RF;
      if (reg_write_m && (rd_m != '0) && (rd_m == rs))
         sel = FWD_MEM;
      else if (reg_write_w && (rd_w != '0) && (rd_w == rs))
         sel = FWD_WB;
      return sel;
   endfunction

endpackage

// File: rtl/pipeline_control_hazard_control_stage_reg.sv
// Generic pipeline register for a control bundle.
// Ports: clk, rst (sync, active-high), clr (sync bubble insert), d, q.
module control_stage_reg #(
   parameter int unsigned WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   // Zero bundle is a bubble: no writes, no branch
   always_ff @(posedge clk) begin
      if (rst || clr) q <= '0;
      else            q <= d;
   end

endmodule

// File: rtl/pipeline_control_hazard.sv
// Control path of a 5-stage RISC-V pipeline: stages the ID control bundle
// through ID/EX, EX/MEM, MEM/WB and derives forwarding, load-use stall,
// branch/jump redirect and flush signals, plus saturating stall/flush counters.
// Ports: clk, rst (sync active-high); *_d ID controls and register addresses;
// zero_e EX ALU flag; staged controls alu_src_e, alu_function_e, mem_write_m,
// reg_write_w, result_src_w, rd_w; hazard outputs forward_a_e, forward_b_e,
// pc_src_e, stall_f, stall_d, flush_d, flush_e (combinational); stall_count,
// flush_count (registered).
module pipeline_control_hazard
   import pipeline_control_hazard_pkg::*;
#(
   parameter int unsigned CNT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 reg_write_d,
   input  logic [1:0]           result_src_d,
   input  logic                 mem_write_d,
   input  logic                 alu_src_d,
   input  logic [2:0]           alu_function_d,
   input  logic                 beq_d,
   input  logic                 bne_d,
   input  logic                 jump_d,
   input  logic                 jalr_d,
   input  logic [4:0]           rs1_d,
   input  logic [4:0]           rs2_d,
   input  logic [4:0]           rd_d,
   input  logic                 zero_e,
   output logic                 alu_src_e,
   output logic [2:0]           alu_function_e,
   output logic                 mem_write_m,
   output logic                 reg_write_w,
   output logic [1:0]           result_src_w,
   output logic [4:0]           rd_w,
   output logic [1:0]           forward_a_e,
   output logic [1:0]           forward_b_e,
   output logic [1:0]           pc_src_e,
   output logic                 stall_f,
   output logic                 stall_d,
   output logic                 flush_d,
   output logic                 flush_e,
   output logic [CNT_WIDTH-1:0] stall_count,
   output logic [CNT_WIDTH-1:0] flush_count
);

   ex_ctrl_t  id_bus, ex_q;
   mem_ctrl_t mem_d, mem_q;
   wb_ctrl_t  wb_d, wb_q;

   logic taken_e;
   logic redirect;
   logic lwstall;

   // Pack ID inputs and the per-stage subsets
   always_comb begin
      id_bus              = '0;
      id_bus.reg_write    = reg_write_d;
      id_bus.result_src   = result_src_d;
      id_bus.mem_write    = mem_write_d;
      id_bus.alu_src      = alu_src_d;
      id_bus.alu_function = alu_function_d;
      id_bus.beq          = beq_d;
      id_bus.bne          = bne_d;
      id_bus.jump         = jump_d;
      id_bus.jalr         = jalr_d;
      id_bus.rs1          = rs1_d;
      id_bus.rs2          = rs2_d;
      id_bus.rd           = rd_d;

      mem_d               = '0;
      mem_d.reg_write     = ex_q.reg_write;
      mem_d.result_src    = ex_q.result_src;
      mem_d.mem_write     = ex_q.mem_write;
      mem_d.rd            = ex_q.rd;

      wb_d                = '0;
      wb_d.reg_write      = mem_q.reg_write;
      wb_d.result_src     = mem_q.result_src;
      wb_d.rd             = mem_q.rd;
   end

   control_stage_reg #(.WIDTH($bits(ex_ctrl_t))) u_id_ex (
      .clk (clk),
      .rst (rst),
      .clr (flush_e),
      .d   (id_bus),
      .q   (ex_q)
   );

   control_stage_reg #(.WIDTH($bits(mem_ctrl_t))) u_ex_mem (
      .clk (clk),
      .rst (rst),
      .clr (1'b0),
      .d   (mem_d),
      .q   (mem_q)
   );

   control_stage_reg #(.WIDTH($bits(wb_ctrl_t))) u_mem_wb (
      .clk (clk),
      .rst (rst),
      .clr (1'b0),
      .d   (wb_d),
      .q   (wb_q)
   );

   assign alu_src_e      = ex_q.alu_src;
   assign alu_function_e = ex_q.alu_function;
   assign mem_write_m    = mem_q.mem_write;
   assign reg_write_w    = wb_q.reg_write;
   assign result_src_w   = wb_q.result_src;
   assign rd_w           = wb_q.rd;

   // Redirect, load-use and flush resolution; a redirect cancels the stall
   // because the ID instruction is on the wrong path anyway
   always_comb begin
      taken_e = (ex_q.beq & zero_e) | (ex_q.bne & ~zero_e) | ex_q.jump;

      pc_src_e = PC_SRC_SEQ;
      if (ex_q.jalr)   pc_src_e = PC_SRC_JALR;
      else if (taken_e) pc_src_e = PC_SRC_TARGET;

      redirect = (pc_src_e != PC_SRC_SEQ);

      lwstall = (ex_q.result_src == RESULT_MEM) && (ex_q.rd != '0) &&
                ((ex_q.rd == rs1_d) || (ex_q.rd == rs2_d));

      stall_f = lwstall & ~redirect;
      stall_d = lwstall & ~redirect;
      flush_d = redirect;
      flush_e = redirect | lwstall;

      forward_a_e = fwd_sel(ex_q.rs1, mem_q.reg_write, mem_q.rd,
                            wb_q.reg_write, wb_q.rd);
      forward_b_e = fwd_sel(ex_q.rs2, mem_q.reg_write, mem_q.rd,
                            wb_q.reg_write, wb_q.rd);
   end

   // Saturating performance counters
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_count <= '0;
         flush_count <= '0;
      end else begin
         if (stall_d && (stall_count != '1))
            stall_count <= stall_count + CNT_WIDTH'(1);
         if ((flush_d || flush_e) && (flush_count != '1))
            flush_count <= flush_count + CNT_WIDTH'(1);
      end
   end

endmodule

// File: tb/tb_pipeline_control_hazard.sv
// Directed bench for pipeline_control_hazard with 4-bit counters.
module tb_pipeline_control_hazard;
   import pipeline_control_hazard_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic       reg_write_d;
   logic [1:0] result_src_d;
   logic       mem_write_d;
   logic       alu_src_d;
   logic [2:0] alu_function_d;
   logic       beq_d, bne_d, jump_d, jalr_d;
   logic [4:0] rs1_d, rs2_d, rd_d;
   logic       zero_e;
   logic       alu_src_e;
   logic [2:0] alu_function_e;
   logic       mem_write_m;
   logic       reg_write_w;
   logic [1:0] result_src_w;
   logic [4:0] rd_w;
   logic [1:0] forward_a_e, forward_b_e, pc_src_e;
   logic       stall_f, stall_d, flush_d, flush_e;
   logic [3:0] stall_count, flush_count;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   pipeline_control_hazard #(.CNT_WIDTH(4)) dut (
      .clk            (clk),
      .rst            (rst),
      .reg_write_d    (reg_write_d),
      .result_src_d   (result_src_d),
      .mem_write_d    (mem_write_d),
      .alu_src_d      (alu_src_d),
      .alu_function_d (alu_function_d),
      .beq_d          (beq_d),
      .bne_d          (bne_d),
      .jump_d         (jump_d),
      .jalr_d         (jalr_d),
      .rs1_d          (rs1_d),
      .rs2_d          (rs2_d),
      .rd_d           (rd_d),
      .zero_e         (zero_e),
      .alu_src_e      (alu_src_e),
      .alu_function_e (alu_function_e),
      .mem_write_m    (mem_write_m),
      .reg_write_w    (reg_write_w),
      .result_src_w   (result_src_w),
      .rd_w           (rd_w),
      .forward_a_e    (forward_a_e),
      .forward_b_e    (forward_b_e),
      .pc_src_e       (pc_src_e),
      .stall_f        (stall_f),
      .stall_d        (stall_d),
      .flush_d        (flush_d),
      .flush_e        (flush_e),
      .stall_count    (stall_count),
      .flush_count    (flush_count)
   );

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_id(input logic rw, input logic [1:0] rs, input logic mw,
                         input logic as, input logic [2:0] af, input logic bq,
                         input logic bn, input logic j, input logic jr,
                         input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd);
      reg_write_d = rw;  result_src_d = rs;  mem_write_d = mw;  alu_src_d = as;
      alu_function_d = af;  beq_d = bq;  bne_d = bn;  jump_d = j;  jalr_d = jr;
      rs1_d = r1;  rs2_d = r2;  rd_d = rd;
   endtask

   task automatic nop_id();
      set_id(1'b0, RESULT_ALU, 1'b0, 1'b0, ALU_ADD, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
   endtask

   task automatic alu_id(input logic [4:0] rd, input logic [4:0] r1, input logic [4:0] r2,
                         input logic [2:0] af);
      set_id(1'b1, RESULT_ALU, 1'b0, 1'b0, af, 1'b0, 1'b0, 1'b0, 1'b0, r1, r2, rd);
   endtask

   task automatic lw_id(input logic [4:0] rd, input logic [4:0] r1);
      set_id(1'b1, RESULT_MEM, 1'b0, 1'b1, ALU_ADD, 1'b0, 1'b0, 1'b0, 1'b0, r1, 5'd0, rd);
   endtask

   task automatic rand_id();
      set_id(1'($urandom), 2'($urandom), 1'($urandom), 1'($urandom), 3'($urandom),
             1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
             5'($urandom), 5'($urandom), 5'($urandom));
      zero_e = 1'($urandom);
   endtask

   task automatic drain();
      nop_id();
      zero_e = 1'b0;
      repeat (3) tick();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset with random ID activity
      rst = 1'b1;
      rand_id();
      tick();
      rand_id();
      tick();
      chk("rst_staged", 16'({alu_src_e, alu_function_e, mem_write_m, reg_write_w,
                              result_src_w, rd_w}), 16'h0000);
      chk("rst_hazard", 16'({forward_a_e, forward_b_e, pc_src_e, stall_f, stall_d,
                              flush_d, flush_e}), 16'h0000);
      chk("rst_counts", 16'({stall_count, flush_count}), 16'h0000);
      rst = 1'b0;
      drain();

      // Back-to-back ALU dependency: MEM forward
      alu_id(5'd5, 5'd1, 5'd2, ALU_ADD);  tick();
      alu_id(5'd6, 5'd5, 5'd1, ALU_SUB);  tick();
      nop_id();  #1;
      chk("b2b_fwd_a", 16'(forward_a_e), 16'(FWD_MEM));
      chk("b2b_fwd_b", 16'(forward_b_e), 16'(FWD_RF));
      chk("b2b_alu_fn", 16'(alu_function_e), 16'(ALU_SUB));
      drain();

      // One nop between: WB forward on operand B
      alu_id(5'd5, 5'd1, 5'd2, ALU_ADD);  tick();
      nop_id();                            tick();
      alu_id(5'd6, 5'd1, 5'd5, ALU_SUB);  tick();
      nop_id();  #1;
      chk("gap_fwd_a", 16'(forward_a_e), 16'(FWD_RF));
      chk("gap_fwd_b", 16'(forward_b_e), 16'(FWD_WB));
      chk("gap_wb", 16'({reg_write_w, result_src_w, rd_w}), 16'({1'b1, RESULT_ALU, 5'd5}));
      drain();

      // Both MEM and WB write x5: MEM wins
      alu_id(5'd5, 5'd1, 5'd2, ALU_ADD);  tick();
      alu_id(5'd5, 5'd3, 5'd4, ALU_OR);   tick();
      alu_id(5'd6, 5'd5, 5'd5, ALU_SUB);  tick();
      nop_id();  #1;
      chk("prio_fwd", 16'({forward_a_e, forward_b_e}), 16'({FWD_MEM, FWD_MEM}));
      drain();

      // x0 producer never forwards
      alu_id(5'd0, 5'd1, 5'd2, ALU_ADD);  tick();
      alu_id(5'd6, 5'd0, 5'd0, ALU_SUB);  tick();
      nop_id();  #1;
      chk("x0_fwd", 16'({forward_a_e, forward_b_e}), 16'({FWD_RF, FWD_RF}));
      drain();

      // Load-use: one stall cycle, then WB forward
      lw_id(5'd5, 5'd1);  tick();
      alu_id(5'd7, 5'd5, 5'd2, ALU_ADD);  #1;
      chk("lu_stall", 16'({stall_f, stall_d, flush_d, flush_e}), 16'b1101);
      chk("lu_cnt0", 16'(stall_count), 16'd0);
      tick();
      chk("lu_release", 16'({stall_f, stall_d, flush_d, flush_e}), 16'b0000);
      chk("lu_counts", 16'({stall_count, flush_count}), 16'({4'd1, 4'd1}));
      tick();
      nop_id();  #1;
      chk("lu_fwd_a", 16'(forward_a_e), 16'(FWD_WB));
      chk("lu_wb", 16'({reg_write_w, result_src_w, rd_w}), 16'({1'b1, RESULT_MEM, 5'd5}));
      drain();

      // Store: staged alu_src and mem_write latency
      set_id(1'b0, RESULT_ALU, 1'b1, 1'b1, ALU_ADD, 1'b0, 1'b0, 1'b0, 1'b0, 5'd1, 5'd2, 5'd0);
      tick();
      nop_id();  #1;
      chk("sw_ex", 16'({alu_src_e, mem_write_m}), 16'b10);
      tick();
      chk("sw_mem", 16'({alu_src_e, mem_write_m}), 16'b01);
      drain();

      // beq taken
      set_id(1'b0, RESULT_ALU, 1'b0, 1'b0, ALU_SUB, 1'b1, 1'b0, 1'b0, 1'b0, 5'd1, 5'd2, 5'd0);
      tick();
      nop_id();  zero_e = 1'b1;  #1;
      chk("beq_t_pc", 16'(pc_src_e), 16'(PC_SRC_TARGET));
      chk("beq_t_fl", 16'({stall_f, flush_d, flush_e}), 16'b011);
      tick();
      zero_e = 1'b0;  #1;
      chk("beq_t_after", 16'({pc_src_e, flush_d, flush_e}), 16'b0000);
      chk("beq_t_fcnt", 16'(flush_count), 16'd2);

      // beq not taken
      set_id(1'b0, RESULT_ALU, 1'b0, 1'b0, ALU_SUB, 1'b1, 1'b0, 1'b0, 1'b0, 5'd1, 5'd2, 5'd0);
      tick();
      zero_e = 1'b0;
      set_id(1'b0, RESULT_ALU, 1'b0, 1'b0, ALU_SUB, 1'b0, 1'b1, 1'b0, 1'b0, 5'd1, 5'd2, 5'd0);
      #1;
      chk("beq_nt", 16'({pc_src_e, flush_d, flush_e}), 16'b0000);

      // bne taken (zero_e=0)
      tick();
      nop_id();  zero_e = 1'b0;  #1;
      chk("bne_t", 16'({pc_src_e, flush_d, flush_e}), 16'({PC_SRC_TARGET, 2'b11}));
      tick();

      // bne not taken (zero_e=1)
      set_id(1'b0, RESULT_ALU, 1'b0, 1'b0, ALU_SUB, 1'b0, 1'b1, 1'b0, 1'b0, 5'd1, 5'd2, 5'd0);
      tick();
      zero_e = 1'b1;
      set_id(1'b1, RESULT_PC4, 1'b0, 1'b1, ALU_ADD, 1'b0, 1'b0, 1'b0, 1'b1, 5'd2, 5'd0, 5'd1);
      #1;
      chk("bne_nt", 16'({pc_src_e, flush_d, flush_e}), 16'b0000);

      // jalr
      tick();
      nop_id();  zero_e = 1'b0;  #1;
      chk("jalr", 16'({pc_src_e, flush_d, flush_e}), 16'({PC_SRC_JALR, 2'b11}));
      tick();
      chk("jalr_fcnt", 16'(flush_count), 16'd4);

      // Taken jump with load-result bundle in EX while ID reads x5
      set_id(1'b1, RESULT_MEM, 1'b0, 1'b0, ALU_ADD, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd5);
      tick();
      alu_id(5'd7, 5'd5, 5'd2, ALU_ADD);  #1;
      chk("sim_hazard", 16'({pc_src_e, stall_f, stall_d, flush_d, flush_e}),
          16'({PC_SRC_TARGET, 4'b0011}));
      tick();
      chk("sim_counts", 16'({stall_count, flush_count}), 16'({4'd1, 4'd5}));
      drain();

      // Saturation: repeated lw x5,x5 stalls every other cycle
      lw_id(5'd5, 5'd5);
      repeat (40) tick();
      chk("sat_counts", 16'({stall_count, flush_count}), 16'({4'hF, 4'hF}));

      // Reset mid-run
      rst = 1'b1;
      tick();
      chk("rst_mid_counts", 16'({stall_count, flush_count}), 16'h0000);
      chk("rst_mid_pipe", 16'({reg_write_w, rd_w, stall_f, flush_e}), 16'h0000);
      rst = 1'b0;
      nop_id();
      tick();
      chk("post_rst", 16'({forward_a_e, forward_b_e, pc_src_e, stall_d, flush_d,
                            alu_src_e, mem_write_m, reg_write_w}), 16'h0000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
